// File: rtl/decode_issue_queue.sv
// Decode-issue queue: classifies fetched instructions, expands RV32I immediates at enqueue, buffers them in a registered FIFO.
// Optional macro DECODE_ILLEGAL_CHECK_EN stores a per-entry illegal-opcode flag.
module decode_issue_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [2:0]            imm_type_o,
  output logic                  illegal_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] imm_mem   [DEPTH];
  logic [2:0]            type_mem  [DEPTH];

  logic [6:0]         opcode;
  logic signed [31:0] dec_imm32;
  logic [2:0]         dec_type;

  // Handshake flags come only from the registered state, never from the opposite side.
  assign in_ready_o  = (state != FULL);
  assign out_valid_o = (state != EMPTY);
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign opcode = instruction_i[6:0];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    dec_type  = TYPE_NONE;
    dec_imm32 = '0;
    unique case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_type  = TYPE_I;
        dec_imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      7'b0100011: begin
        dec_type  = TYPE_S;
        dec_imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      end
      7'b1100011: begin
        dec_type  = TYPE_B;
        dec_imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                     instruction_i[30:25], instruction_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_type  = TYPE_U;
        dec_imm32 = {instruction_i[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_type  = TYPE_J;
        dec_imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                     instruction_i[20], instruction_i[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    count_next = count;
    if (flush_i)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (pop && !push)
      count_next = count - CNT_W'(1);

    state_next = PARTIAL;
    if (count_next == '0)
      state_next = EMPTY;
    else if (count_next == CNT_W'(DEPTH))
      state_next = FULL;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: storage is reset because the head fields must read zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        imm_mem[i]   <= '0;
        type_mem[i]  <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= instruction_i;
      pc_mem[wr_ptr]    <= pc_i;
      imm_mem[wr_ptr]   <= DATA_WIDTH'(dec_imm32);
      type_mem[wr_ptr]  <= dec_type;
    end
  end

  assign instruction_o = instr_mem[rd_ptr];
  assign pc_o          = pc_mem[rd_ptr];
  assign imm_o         = imm_mem[rd_ptr];
  assign imm_type_o    = type_mem[rd_ptr];

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic ill_mem [DEPTH];
  logic dec_illegal;

  // R-type is a known opcode with no immediate; anything else unclassified is illegal.
  assign dec_illegal = (dec_type == TYPE_NONE) && (opcode != 7'b0110011);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ill_mem[i] <= 1'b0;
    end else if (push) begin
      ill_mem[wr_ptr] <= dec_illegal;
    end
  end

  assign illegal_o = ill_mem[rd_ptr];
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_issue_queue.sv
// Randomized bench for decode_issue_queue against a queue-based reference model.
module tb_decode_issue_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, illegal_o;
  logic [DW-1:0] instruction_i, pc_i, instruction_o, pc_o, imm_o;
  logic [2:0]    imm_type_o;

  decode_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instruction_i(instruction_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instruction_o(instruction_o), .pc_o(pc_o), .imm_o(imm_o),
    .imm_type_o(imm_type_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] ins; logic [31:0] pc; } entry_t;
  entry_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Immediates rebuilt with signed arithmetic from field positions.
  function automatic void ref_decode(input logic [31:0] ins, output logic [31:0] imm,
                                     output logic [31:0] ty, output logic [31:0] ill);
    int s;
    s   = int'(ins);
    imm = 0;
    ty  = 0;
    ill = 0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin ty = 1; imm = s >>> 20; end
      7'h23: begin ty = 2; imm = (s >>> 25) * 32 + int'(ins[11:7]); end
      7'h63: begin ty = 3; imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048
                                 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
      7'h37, 7'h17: begin ty = 4; imm = ins & 32'hFFFFF000; end
      7'h6F: begin ty = 5; imm = (s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096
                                 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2; end
      default: begin
`ifdef DECODE_ILLEGAL_CHECK_EN
        ill = (ins[6:0] != 7'h33) ? 1 : 0;
`endif
      end
    endcase
  endfunction

  task automatic compare_outputs();
    logic [31:0] imm, ty, ill;
    check("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready_o), 32'(q.size() != DEPTH));
    if (q.size() != 0) begin
      ref_decode(q[0].ins, imm, ty, ill);
      check("instruction", instruction_o, q[0].ins);
      check("pc", pc_o, q[0].pc);
      check("imm", imm_o, imm);
      check("imm_type", 32'(imm_type_o), ty);
      check("illegal", 32'(illegal_o), ill);
    end
  endtask

  // One clock: drive inputs at negedge, compare registered outputs, then advance the model.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit do_push, do_pop;
    @(negedge clk_i);
    in_valid_i = v; instruction_i = ins; pc_i = pc; out_ready_i = ordy; flush_i = fl;
    #1;
    compare_outputs();
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() > 0) && ordy && !fl;
    @(posedge clk_i);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{ins: ins, pc: pc});
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00};
    r = $urandom();
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  logic [31:0] seq_ins [4];
  logic [31:0] seq_imm [4];
  logic [2:0]  seq_ty  [4];

  initial begin
    seq_ins = '{32'h00112623, 32'hFE000EE3, 32'h12345037, 32'h0080006F};
    seq_imm = '{32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h00000008};
    seq_ty  = '{3'd2, 3'd3, 3'd4, 3'd5};

    rst_i = 1'b1; flush_i = 0; in_valid_i = 0; out_ready_i = 0;
    instruction_i = 0; pc_i = 0;
    #12;
    check("rst_out_valid", 32'(out_valid_o), 0);
    check("rst_in_ready", 32'(in_ready_o), 1);
    check("rst_instruction", instruction_o, 0);
    check("rst_imm", imm_o, 0);
    @(negedge clk_i); rst_i = 1'b0;

    // Single addi, one-cycle latency.
    step(1, 32'hFFF00093, 32'h100, 1, 0);
    #1;
    check("addi_valid", 32'(out_valid_o), 1);
    check("addi_imm", imm_o, 32'hFFFFFFFF);
    check("addi_type", 32'(imm_type_o), 1);
    check("addi_pc", pc_o, 32'h100);
    step(0, 0, 0, 1, 0);

    // Back-to-back stream, one per cycle.
    for (int k = 0; k < 4; k++) begin
      step(1, seq_ins[k], 32'h200 + 32'(4 * k), 1, 0);
      #1;
      check("seq_imm", imm_o, seq_imm[k]);
      check("seq_type", 32'(imm_type_o), 32'(seq_ty[k]));
    end
    step(0, 0, 0, 1, 0);

    // Backpressure: third instruction held until after the first pop.
    step(1, 32'h00100093, 32'h300, 0, 0);
    step(1, 32'h00200093, 32'h304, 0, 0);
    #1 check("full_in_ready", 32'(in_ready_o), 0);
    step(1, 32'h00300093, 32'h308, 0, 0);
    step(1, 32'h00300093, 32'h308, 1, 0);
    step(1, 32'h00300093, 32'h308, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);

    // Flush while full with a push offered.
    step(1, 32'h00400093, 32'h400, 0, 0);
    step(1, 32'h00500093, 32'h404, 0, 0);
    step(1, 32'h00600093, 32'h408, 1, 1);
    #1;
    check("flush_valid", 32'(out_valid_o), 0);
    check("flush_ready", 32'(in_ready_o), 1);
    step(0, 0, 0, 1, 0);

    // Asynchronous reset with one entry queued.
    step(1, 32'h00700093, 32'h500, 0, 0);
    @(negedge clk_i);
    in_valid_i = 0;
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid_o), 0);
    check("arst_instruction", instruction_o, 0);
    check("arst_pc", pc_o, 0);
    check("arst_imm", imm_o, 0);
    check("arst_type", 32'(imm_type_o), 0);
    q.delete();
    @(negedge clk_i); rst_i = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);

    // Illegal-opcode flag.
    step(1, 32'h0000007F, 32'h600, 1, 0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    #1 check("illegal_7f", 32'(illegal_o), 1);
`else
    #1 check("illegal_7f", 32'(illegal_o), 0);
`endif
    check("illegal_7f_type", 32'(imm_type_o), 0);
    step(1, 32'h002081B3, 32'h604, 1, 0);
    #1 check("illegal_add", 32'(illegal_o), 0);
    step(0, 0, 0, 1, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 3) != 0, rand_ins(), $urandom(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Buffered decode-issue controller between fetch and execute. Accepts fetched instruction/PC pairs over a valid/ready handshake, classifies the opcode, and expands the matching immediate when the instruction is enqueued. Entries are stored in a small FIFO, so every output is a register with no combinational path from input to output. Flush support covers branch/jump redirects.

## Interface
- DATA_WIDTH, 32, instruction, PC and immediate width (from `defines`)
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-high reset
- flush_i  input  1  discard all entries (redirect)
- in_valid_i  input  1  fetch offers an instruction
- in_ready_o  output  1  queue can accept
- instruction_i  input  DATA_WIDTH  fetched instruction word
- pc_i  input  DATA_WIDTH  PC of instruction_i
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  execute consumes the head
- instruction_o  output  DATA_WIDTH  head instruction
- pc_o  output  DATA_WIDTH  head PC
- imm_o  output  DATA_WIDTH  head immediate, expanded per imm_type_o
- imm_type_o  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
- illegal_o  output  1  head opcode unrecognised (see Configuration)

## Operation
- Opcode [6:0] → type: 0010011/0000011/1100111/1110011 → I; 0100011 → S; 1100011 → B; 0110111/0010111 → U; 1101111 → J; anything else → NONE with imm 0.
- Immediates use standard RV32I formats, sign-extended from bit 31. B and J have bit 0 = 0. U has [11:0] = 0.
- Classification and expansion happen at enqueue. Each entry stores {instruction, pc, imm, type, illegal}.
- Count FSM states: EMPTY (count 0), PARTIAL (0 < count < DEPTH), FULL (count = DEPTH).
- push = in_valid_i & in_ready_o & ~flush_i.
- pop = out_valid_o & out_ready_i & ~flush_i.
- Push only: count +1. Pop only: count −1. Push and pop together: count unchanged; both pointers advance.
- Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- in_ready_o = (count != DEPTH). It depends only on registered count, never on out_ready_i, so a full queue does not accept in the same cycle it pops.
- out_valid_o = (count != 0). Head fields are driven from storage[rd_ptr].
- flush_i has priority over everything. Next cycle: count = 0 and pointers = 0. A push or pop presented in the flush cycle is dropped.
- The head's output fields hold their value while out_valid_o = 1 and out_ready_i = 0.

## Timing
- Reset (async assert): count 0, pointers 0, all storage 0, out_valid_o 0, in_ready_o 1. instruction_o, pc_o, imm_o, imm_type_o and illegal_o all read 0.
- Latency: an instruction pushed at edge N appears on the outputs after edge N (out_valid_o high in cycle N+1) when the queue was empty.
- Throughput: 1 instruction/cycle sustained with out_ready_i held high.
- Reset asserted mid-operation clears everything immediately. After deassertion the queue restarts EMPTY with no residual entries.
- When empty, data outputs show whichever storage entry rd_ptr points to. They are valid only with out_valid_o.

## Configuration
- DECODE_ILLEGAL_CHECK_EN defined: the NONE class is split. Opcode 0110011 (R-type) → NONE, illegal 0. Any opcode not listed above → NONE, illegal 1. illegal_o reports the head entry's flag.
- Not defined: illegal_o is tied to 0 and no illegal flag is stored. Unknown opcodes are treated as NONE with imm 0.

## Test plan
- Push 0xFFF00093 (addi x1,x0,-1), pc 0x100, out_ready_i 1 → next cycle out_valid_o 1, imm_o 0xFFFFFFFF, imm_type_o 1, pc_o 0x100.
- Back-to-back push of 0x00112623, 0xFE000EE3, 0x12345037, 0x0080006F → in order: imm 0x0000000C/S, 0xFFFFFFFC/B, 0x12345000/U, 0x00000008/J, one per cycle.
- Hold out_ready_i 0 and offer 3 instructions → in_ready_o drops after 2 accepts (DEPTH 2). The third is held by fetch and accepted after the first pop. Order is preserved and pointers wrap.
- Queue full, assert flush_i with in_valid_i 1 → next cycle out_valid_o 0, in_ready_o 1, and the flush-cycle instruction is absent.
- Assert rst_i mid-stream with 1 entry queued → outputs go to 0 immediately. After release, out_valid_o stays 0 until a new push.
- With DECODE_ILLEGAL_CHECK_EN, push 0x0000007F → illegal_o 1, imm_type_o 0. Push 0x002081B3 (add) → illegal_o 0. Without the macro, illegal_o stays 0 for both.
